// File: rtl/peripheral_spi_pkg.sv
// peripheral_spi_pkg: register indices, FSM states and STATUS bit positions
// shared by the SPI master and its users.
package peripheral_spi_pkg;

    localparam logic [2:0] REG_TX     = 3'd0;
    localparam logic [2:0] REG_RX     = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } spi_state_t;

endpackage

// File: rtl/peripheral_spi_sync2.sv
// spi_sync2: two-flop synchroniser bringing miso into the clk domain.
module spi_sync2 (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/peripheral_spi.sv
// peripheral_spi: memory-mapped SPI master (mode 0, MSB first, 8-bit frames)
// with TX/RX/STATUS/CTRL registers on the SOC peripheral bus.
module peripheral_spi
    import peripheral_spi_pkg::*;
#(
    parameter logic [7:0] DIV_RESET = 8'd12
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        ss_n
);

    spi_state_t  state, state_next;
    logic [7:0]  cnt, div, div_act, shreg, rx_byte, shifted;
    logic [2:0]  bit_cnt, idx;
    logic [31:0] rd_data;
    logic        done, busy, miso_s, tick, start, shift, finish, wr_en, rd_en;
    logic        unused_bits;

    spi_sync2 u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (miso),
        .q      (miso_s)
    );

    assign unused_bits = ^{d_in[31:9], addr[1:0]};
    assign idx         = addr[4:2];
    assign wr_en       = cs & wr;
    assign rd_en       = cs & rd & ~wr;
    assign busy        = state != IDLE;
    assign tick        = cnt == div_act;
    assign shifted     = {shreg[6:0], miso_s};

    always_comb begin
        state_next = state;
        start      = 1'b0;
        shift      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (wr_en && idx == REG_TX) begin
                start      = 1'b1;
                state_next = LOW;
            end
            LOW: if (tick) state_next = HIGH;
            HIGH: if (tick) begin
                shift      = 1'b1;
                finish     = bit_cnt == 3'd7;
                state_next = finish ? IDLE : LOW;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (idx)
            REG_RX:     rd_data[7:0] = rx_byte;
            REG_STATUS: begin
                rd_data[STAT_BUSY] = busy;
                rd_data[STAT_DONE] = done;
            end
            REG_CTRL:   rd_data[8:0] = {ss_n, div};
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            ss_n    <= 1'b1;
            done    <= 1'b0;
            rx_byte <= 8'd0;
            div     <= DIV_RESET;
            div_act <= 8'd1;
            cnt     <= 8'd0;
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
            d_out   <= 32'd0;
        end else begin
            state <= state_next;
            sclk  <= state_next == HIGH;
            cnt   <= (start || tick) ? 8'd0 : cnt + 8'd1;
            // Divider is latched here so CTRL writes mid-frame only affect the next frame.
            if (start) begin
                shreg   <= d_in[7:0];
                mosi    <= d_in[7];
                bit_cnt <= 3'd0;
                div_act <= (div == 8'd0) ? 8'd1 : div;
            end
            if (shift) begin
                shreg   <= shifted;
                bit_cnt <= bit_cnt + 3'd1;
                if (finish) rx_byte <= shifted;
                else mosi <= shifted[7];
            end
            // A completing frame wins over a simultaneous RX read.
            done <= finish | (done & ~(rd_en && idx == REG_RX));
            if (rd_en) d_out <= rd_data;
            if (wr_en && idx == REG_CTRL) begin
                ss_n <= d_in[8];
                div  <= d_in[7:0];
            end
        end
    end

endmodule
